// File: rtl/sq_sequence_unit_if.sv
// Write-bus side of the sequence unit: load strobe plus the WL bus.
// The bus master drives both; the sequence unit samples them.
interface sq_sequence_unit_if #(
  parameter int DW = 16
);
  logic          nisq;
  logic [DW-1:0] wl;

  modport master (
    output nisq,
    output wl
  );

  modport slave (
    input nisq,
    input wl
  );
endinterface

// File: rtl/sq_sequence_unit.sv
// Sequence register: order/quarter code, extend and interrupt flags,
// and priority insertion of a RUPT code at the instruction boundary.
module sq_sequence_unit #(
  parameter int              DW       = 16,
  parameter int              OP_W     = 3,
  parameter int              QC_W     = 2,
  parameter int              NUM_RUPT = 4,
  parameter logic [OP_W-1:0] RUPT_OP  = '0,
  parameter logic [QC_W-1:0] RUPT_QC  = '1,
  localparam int VW   = (NUM_RUPT > 1) ? $clog2(NUM_RUPT) : 1,
  localparam int NDEC = 1 << OP_W
) (
  input  logic                SIM_CLK,
  input  logic                SIM_RST,
  input  logic                gojam,
  sq_sequence_unit_if.slave   wb,
  input  logic                extpls,
  input  logic                inhpls,
  input  logic                relpls,
  input  logic                resume,
  input  logic                mnhrpt,
  input  logic [NUM_RUPT-1:0] rupt_req,
  output logic [OP_W-1:0]     sq,
  output logic [QC_W-1:0]     qc,
  output logic                sqr10,
  output logic                sqext,
  output logic [NDEC-1:0]     sq_dec,
  output logic                futext,
  output logic                inhint,
  output logic                iip,
  output logic [NUM_RUPT-1:0] rupt_pend,
  output logic                rupt_taken,
  output logic [VW-1:0]       rupt_vec
);

  localparam int QC_HI = DW - OP_W - 1;
  localparam int R10_B = DW - OP_W - QC_W - 1;

  logic [NUM_RUPT-1:0] hit;
  logic [NUM_RUPT-1:0] clr;
  logic [VW-1:0]       vec_nx;
  logic                found;
  logic                take;
  logic                wl_unused;

  assign wl_unused = ^wb.wl[R10_B-1:0];

  // lowest index wins
  always_comb begin
    hit    = '0;
    vec_nx = '0;
    found  = 1'b0;
    for (int i = 0; i < NUM_RUPT; i++) begin
      if (!found && rupt_pend[i]) begin
        found  = 1'b1;
        vec_nx = VW'(i);
        hit[i] = 1'b1;
      end
    end
  end

  // never split EXTEND from the instruction it extends
  assign take = wb.nisq & (|rupt_pend)
              & ~inhint & ~iip & ~futext
              & ~mnhrpt & ~extpls;

  assign clr = take ? hit : '0;

  always_comb begin
    sq_dec = '0;
    for (int i = 0; i < NDEC; i++) begin
      sq_dec[i] = (sq == OP_W'(i));
    end
  end

  always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
    if (SIM_RST) begin
      sq         <= '0;
      qc         <= '0;
      sqr10      <= 1'b0;
      sqext      <= 1'b0;
      futext     <= 1'b0;
      inhint     <= 1'b1;
      iip        <= 1'b0;
      rupt_pend  <= '0;
      rupt_taken <= 1'b0;
      rupt_vec   <= '0;
    end else if (gojam) begin
      sq         <= '0;
      qc         <= '0;
      sqr10      <= 1'b0;
      sqext      <= 1'b0;
      futext     <= 1'b0;
      inhint     <= 1'b1;
      iip        <= 1'b0;
      rupt_pend  <= rupt_pend | rupt_req;
      rupt_taken <= 1'b0;
      rupt_vec   <= '0;
    end else begin
      rupt_pend  <= (rupt_pend | rupt_req) & ~clr;
      rupt_taken <= take;

      if (take) begin
        sq       <= RUPT_OP;
        qc       <= RUPT_QC;
        sqr10    <= 1'b0;
        sqext    <= 1'b0;
        rupt_vec <= vec_nx;
      end else if (wb.nisq) begin
        sq    <= wb.wl[DW-1 -: OP_W];
        qc    <= wb.wl[QC_HI -: QC_W];
        sqr10 <= wb.wl[R10_B];
        sqext <= futext;
      end

      if (extpls) begin
        futext <= 1'b1;
      end else if (wb.nisq && !take) begin
        futext <= 1'b0;
      end

      if (inhpls) begin
        inhint <= 1'b1;
      end else if (relpls) begin
        inhint <= 1'b0;
      end

      if (take) begin
        iip <= 1'b1;
      end else if (resume) begin
        iip <= 1'b0;
      end
    end
  end

endmodule
